// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store bus arbiter.
//   Contents: arbiter state encoding, default widths, timeout default and
//   the full-word byte-enable value used for instruction fetches.
package bus_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned TMO_W       = 8;
  localparam int unsigned DEF_TMO_CYC = 255;

  // Fetches always read a whole instruction word.
  localparam logic [SEL_W-1:0] SEL_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_MEM_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_tmo_cnt.sv
// Transfer timeout counter for the bus arbiter.
//   clk      core clock
//   rst      asynchronous active-low reset
//   clr      zero the count (held while the arbiter is idle)
//   en       one busy cycle passed without ack/err
//   expire_c combinational: this enabled cycle brings the count to LIMIT
// The count saturates at all-ones so it can never wrap back into range.
module bus_arbiter_tmo_cnt #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt_q;

  // Saturating cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expiry is flagged on the cycle whose increment would reach LIMIT.
  assign expire_c = en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single memory bus between instruction fetch and the MEM stage.
//   clk, rst                  core clock; asynchronous active-low reset
//   if_req_i/if_addr_i        fetch request and address (from pc_reg)
//   if_flush_i                branch taken: kill the current/pending fetch
//   if_rdata_o/if_valid_o     fetched word and its 1-cycle completion pulse
//   if_err_o                  1-cycle fetch error/timeout pulse
//   stallreq_if_o             fetch pending (combinational)
//   mem_req_i/we/sel/addr/wdata  load/store request
//   mem_rdata_o/mem_valid_o   load data and 1-cycle completion pulse
//   mem_err_o                 1-cycle load/store error/timeout pulse
//   stallreq_mem_o            load/store pending (combinational)
//   bus_cyc_o/bus_stb_o       transfer active (identical)
//   bus_we_o/sel/addr/wdata   registered request to the slave
//   bus_rdata_i/ack_i/err_i   slave response
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_err_o,
  output logic              stallreq_if_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_valid_o,
  output logic              mem_err_o,
  output logic              stallreq_mem_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i
);

  arb_state_e        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              if_err_q, if_err_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_err_q, mem_err_d;
  logic              discard_q, discard_d;
  logic              tmo_clr, tmo_en, tmo_expire;
  logic              kill;

  bus_arbiter_tmo_cnt #(
    .CNT_W (TMO_W),
    .LIMIT (TMO_CYC)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .expire_c (tmo_expire)
  );

  // State and all response/request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_err_q   <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      mem_valid_q <= mem_valid_d;
      mem_err_q   <= mem_err_d;
      discard_q   <= discard_d;
    end
  end

  // A flush seen in any fetch cycle, including the completing one, kills the result.
  assign kill = discard_q || if_flush_i;

  // Next-state, request latch and response pulses.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    mem_valid_d = 1'b0;
    mem_err_d   = 1'b0;
    discard_d   = discard_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_clr   = 1'b1;
        discard_d = 1'b0;
        // The MEM side holds the older instruction, so it wins.
        if (mem_req_i) begin
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          cyc_d   = 1'b1;
          state_d = ST_MEM_BUSY;
        end else if (if_req_i && !if_flush_i) begin
          we_d    = 1'b0;
          sel_d   = SEL_FULL;
          addr_d  = if_addr_i;
          cyc_d   = 1'b1;
          state_d = ST_IF_BUSY;
        end
      end

      ST_IF_BUSY: begin
        tmo_en    = !bus_ack_i && !bus_err_i;
        discard_d = kill;
        if (bus_ack_i) begin
          cyc_d      = 1'b0;
          if_rdata_d = bus_rdata_i;
          if_valid_d = !kill;
          discard_d  = 1'b0;
          state_d    = ST_IDLE;
        end else if (bus_err_i || tmo_expire) begin
          cyc_d     = 1'b0;
          if_err_d  = !kill;
          discard_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      ST_MEM_BUSY: begin
        tmo_en = !bus_ack_i && !bus_err_i;
        if (bus_ack_i) begin
          cyc_d       = 1'b0;
          mem_valid_d = 1'b1;
          if (!we_q) begin
            mem_rdata_d = bus_rdata_i;
          end
          state_d = ST_IDLE;
        end else if (bus_err_i || tmo_expire) begin
          cyc_d     = 1'b0;
          mem_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_cyc_o      = cyc_q;
  assign bus_stb_o      = cyc_q;
  assign bus_we_o       = we_q;
  assign bus_sel_o      = sel_q;
  assign bus_addr_o     = addr_q;
  assign bus_wdata_o    = wdata_q;
  assign if_rdata_o     = if_rdata_q;
  assign if_valid_o     = if_valid_q;
  assign if_err_o       = if_err_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_valid_o    = mem_valid_q;
  assign mem_err_o      = mem_err_q;

  // Stall requests drop in the same cycle the completion pulse appears.
  assign stallreq_if_o  = if_req_i && !if_valid_q && !if_err_q;
  assign stallreq_mem_o = mem_req_i && !mem_valid_q && !mem_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fetch, arbitration, flush, timeout,
// bus error, ack/err priority and asynchronous reset mid-transfer.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        if_err_o;
  logic        stallreq_if_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_valid_o;
  logic        mem_err_o;
  logic        stallreq_mem_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_i;

  int errors;
  int checks;

  bus_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_flush_i     (if_flush_i),
    .if_rdata_o     (if_rdata_o),
    .if_valid_o     (if_valid_o),
    .if_err_o       (if_err_o),
    .stallreq_if_o  (stallreq_if_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_valid_o    (mem_valid_o),
    .mem_err_o      (mem_err_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_cyc_o      (bus_cyc_o),
    .bus_stb_o      (bus_stb_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i),
    .bus_err_i      (bus_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bad;
    errors      = 0;
    checks      = 0;
    rst         = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    if_flush_i  = 1'b0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_sel_i   = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    bus_rdata_i = '0;
    bus_ack_i   = 1'b0;
    bus_err_i   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cyc", 64'(bus_cyc_o), 64'd0);
    chk("rst_stb", 64'(bus_stb_o), 64'd0);
    chk("rst_addr", 64'(bus_addr_o), 64'd0);
    chk("rst_sel", 64'(bus_sel_o), 64'd0);
    chk("rst_pulses", 64'({if_valid_o, if_err_o, mem_valid_o, mem_err_o}), 64'd0);
    chk("rst_rdata", 64'({if_rdata_o, mem_rdata_o}), 64'd0);
    rst = 1'b1;
    tick();

    // 1: zero-wait fetch
    if_req_i  = 1'b1;
    if_addr_i = 32'h80;
    #1;
    chk("t1_stall_pre", 64'(stallreq_if_o), 64'd1);
    tick();
    chk("t1_cyc", 64'({bus_cyc_o, bus_stb_o}), 64'd3);
    chk("t1_addr", 64'(bus_addr_o), 64'h80);
    chk("t1_we_sel", 64'({bus_we_o, bus_sel_o}), 64'h0F);
    chk("t1_novalid", 64'(if_valid_o), 64'd0);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h1234_5678;
    tick();
    bus_ack_i = 1'b0;
    chk("t1_valid", 64'(if_valid_o), 64'd1);
    chk("t1_rdata", 64'(if_rdata_o), 64'h1234_5678);
    chk("t1_cyc_drop", 64'(bus_cyc_o), 64'd0);
    chk("t1_stall_rel", 64'(stallreq_if_o), 64'd0);
    if_req_i = 1'b0;
    tick();
    chk("t1_pulse_end", 64'({if_valid_o, bus_cyc_o}), 64'd0);

    // 2: simultaneous requests, MEM store first
    if_req_i    = 1'b1;
    if_addr_i   = 32'h84;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h100;
    mem_wdata_i = 32'hDEAD_BEEF;
    mem_sel_i   = 4'h3;
    tick();
    chk("t2_cyc", 64'(bus_cyc_o), 64'd1);
    chk("t2_addr", 64'(bus_addr_o), 64'h100);
    chk("t2_wdata", 64'(bus_wdata_o), 64'hDEAD_BEEF);
    chk("t2_we_sel", 64'({bus_we_o, bus_sel_o}), 64'h13);
    chk("t2_stalls", 64'({stallreq_if_o, stallreq_mem_o}), 64'd3);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hCAFE_0000;
    tick();
    bus_ack_i = 1'b0;
    chk("t2_mem_valid", 64'(mem_valid_o), 64'd1);
    chk("t2_idle_cyc", 64'(bus_cyc_o), 64'd0);
    chk("t2_store_rdata", 64'(mem_rdata_o), 64'd0);
    chk("t2_stall_if_held", 64'({stallreq_if_o, stallreq_mem_o}), 64'd2);
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    tick();
    chk("t2_if_start", 64'(bus_cyc_o), 64'd1);
    chk("t2_if_addr", 64'(bus_addr_o), 64'h84);
    chk("t2_if_we_sel", 64'({bus_we_o, bus_sel_o}), 64'h0F);
    chk("t2_stall_if", 64'(stallreq_if_o), 64'd1);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0000_A5A5;
    tick();
    bus_ack_i = 1'b0;
    chk("t2_if_valid", 64'({if_valid_o, if_rdata_o}), {31'd0, 1'b1, 32'h0000_A5A5});
    if_req_i = 1'b0;
    tick();

    // 3: flush during fetch, late ack discarded, new address fetched next
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    tick();
    chk("t3_addr", 64'(bus_addr_o), 64'h200);
    if_flush_i = 1'b1;
    tick();
    if_flush_i = 1'b0;
    if_addr_i  = 32'h300;
    chk("t3_hold_addr", 64'({bus_cyc_o, bus_addr_o}), {31'd0, 1'b1, 32'h200});
    tick();
    tick();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0000_0022;
    tick();
    bus_ack_i = 1'b0;
    chk("t3_discard", 64'({if_valid_o, if_err_o}), 64'd0);
    chk("t3_cyc_drop", 64'(bus_cyc_o), 64'd0);
    chk("t3_stall_held", 64'(stallreq_if_o), 64'd1);
    tick();
    chk("t3_new_addr", 64'({bus_cyc_o, bus_addr_o}), {31'd0, 1'b1, 32'h300});
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0000_0033;
    tick();
    bus_ack_i = 1'b0;
    chk("t3_new_valid", 64'({if_valid_o, if_rdata_o}), {31'd0, 1'b1, 32'h0000_0033});
    if_req_i = 1'b0;
    tick();

    // 4: load timeout after 255 busy cycles
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h400;
    mem_sel_i  = 4'hF;
    tick();
    chk("t4_start", 64'(bus_cyc_o), 64'd1);
    bad = 1'b0;
    for (int i = 1; i <= 254; i++) begin
      tick();
      if (!bus_cyc_o || mem_valid_o || mem_err_o || !stallreq_mem_o) bad = 1'b1;
    end
    chk("t4_wait_clean", 64'(bad), 64'd0);
    chk("t4_still_busy", 64'(bus_cyc_o), 64'd1);
    tick();
    chk("t4_cyc_drop", 64'(bus_cyc_o), 64'd0);
    chk("t4_err_pulse", 64'({mem_err_o, mem_valid_o}), 64'd2);
    chk("t4_rdata_kept", 64'(mem_rdata_o), 64'd0);
    chk("t4_stall_rel", 64'(stallreq_mem_o), 64'd0);
    mem_req_i = 1'b0;
    tick();
    chk("t4_err_end", 64'(mem_err_o), 64'd0);

    // 5a: bus error on fetch
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    tick();
    bus_err_i   = 1'b1;
    bus_rdata_i = 32'hBAD0_BAD0;
    tick();
    bus_err_i = 1'b0;
    chk("t5_err", 64'({if_err_o, if_valid_o, bus_cyc_o}), 64'd4);
    chk("t5_rdata_kept", 64'(if_rdata_o), 64'h33);
    if_req_i = 1'b0;
    tick();
    chk("t5_err_end", 64'(if_err_o), 64'd0);

    // 5b: ack and err together, ack wins
    if_req_i  = 1'b1;
    if_addr_i = 32'h504;
    tick();
    bus_ack_i   = 1'b1;
    bus_err_i   = 1'b1;
    bus_rdata_i = 32'h0000_0055;
    tick();
    bus_ack_i = 1'b0;
    bus_err_i = 1'b0;
    chk("t5_ack_wins", 64'({if_valid_o, if_err_o}), 64'd2);
    chk("t5_ack_rdata", 64'(if_rdata_o), 64'h55);
    if_req_i = 1'b0;
    tick();

    // 6: asynchronous reset mid MEM transfer
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h600;
    mem_wdata_i = 32'h1;
    mem_sel_i   = 4'hF;
    tick();
    chk("t6_busy", 64'(bus_cyc_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_drop", 64'({bus_cyc_o, bus_stb_o}), 64'd0);
    chk("t6_async_addr", 64'(bus_addr_o), 64'd0);
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_no_stale", 64'({bus_cyc_o, mem_valid_o, mem_err_o, if_valid_o, if_err_o}), 64'd0);
    if_req_i  = 1'b1;
    if_addr_i = 32'h700;
    tick();
    chk("t6_post_fetch", 64'({bus_cyc_o, bus_addr_o}), {31'd0, 1'b1, 32'h700});
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0000_0077;
    tick();
    bus_ack_i = 1'b0;
    chk("t6_post_valid", 64'({if_valid_o, if_rdata_o}), {31'd0, 1'b1, 32'h0000_0077});
    if_req_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
